// File: rtl/tdm_demux_pkg.sv
// rtl/tdm_demux_pkg.sv - shared state encodings, defaults and sizing helper for the TDM demux
package tdm_demux_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tdm_state_t;

  localparam int DEF_N_CH = 4;
  localparam int DEF_W    = 8;

  // Slot counter width; a single-channel build still needs a 1-bit counter.
  function automatic int cnt_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// rtl/tdm_slot_ctr.sv - slot counter with clear, load-one and wrapping increment
module tdm_slot_ctr
  import tdm_demux_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int CW   = cnt_width(DEF_N_CH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          load_one,
  input  logic          inc,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] LAST = CW'(N_CH - 1);
  localparam logic [CW-1:0] ONE  = (N_CH > 1) ? CW'(1) : '0;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (load_one) begin
      cnt <= ONE;
    end else if (inc) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - TDM receive demultiplexer steering framed words into per-channel registers
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int W    = DEF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din_valid,
  input  logic [W-1:0]      din,
  input  logic              frame_start,
  output logic [N_CH*W-1:0] ch_data,
  output logic [N_CH-1:0]   ch_valid,
  output logic              frame_done,
  output logic              sync_err,
  output logic              busy
);

  localparam int CW = cnt_width(N_CH);
  localparam logic [CW-1:0] LAST = CW'(N_CH - 1);
  localparam logic SINGLE = (N_CH == 1);

  tdm_state_t    state, state_d;
  logic [CW-1:0] cnt;
  logic          wr_en, fd_d, se_d, clr, load_one, inc;
  logic [CW-1:0] wr_idx;

  tdm_slot_ctr #(.N_CH(N_CH), .CW(CW)) u_slot_ctr (
    .clk      (clk),
    .rst      (rst),
    .clear    (clr),
    .load_one (load_one),
    .inc      (inc),
    .cnt      (cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d  = state;
    wr_en    = 1'b0;
    wr_idx   = '0;
    fd_d     = 1'b0;
    se_d     = 1'b0;
    clr      = 1'b0;
    load_one = 1'b0;
    inc      = 1'b0;
    if (din_valid) begin
      if (state == ST_IDLE) begin
        if (frame_start) begin
          wr_en    = 1'b1;
          load_one = 1'b1;
          fd_d     = SINGLE;
          state_d  = ST_RUN;
        end
      end else if (cnt != '0) begin
        // A marker arriving mid-frame resynchronises onto the new frame.
        if (frame_start) begin
          se_d     = 1'b1;
          wr_en    = 1'b1;
          load_one = 1'b1;
        end else begin
          wr_en  = 1'b1;
          wr_idx = cnt;
          inc    = 1'b1;
          fd_d   = (cnt == LAST);
        end
      end else if (frame_start) begin
        wr_en    = 1'b1;
        load_one = 1'b1;
        fd_d     = SINGLE;
      end else begin
        se_d    = 1'b1;
        clr     = 1'b1;
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_data    <= '0;
      ch_valid   <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        ch_valid[k] <= wr_en && (wr_idx == CW'(k));
        if (wr_en && (wr_idx == CW'(k))) ch_data[k*W +: W] <= din;
      end
      frame_done <= fd_d;
      sync_err   <= se_d;
    end
  end

  assign busy = (state == ST_RUN);

endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - directed self-checking bench for tdm_demux (4-channel and 1-channel builds)
module tb_tdm_demux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din_valid = 1'b0;
  logic [7:0]  din = '0;
  logic        frame_start = 1'b0;

  logic [31:0] ch_data;
  logic [3:0]  ch_valid;
  logic        frame_done, sync_err, busy;

  logic [7:0]  ch_data1;
  logic [0:0]  ch_valid1;
  logic        frame_done1, sync_err1, busy1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tdm_demux #(.N_CH(4), .W(8)) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .frame_start(frame_start),
    .ch_data(ch_data), .ch_valid(ch_valid), .frame_done(frame_done),
    .sync_err(sync_err), .busy(busy)
  );

  tdm_demux #(.N_CH(1), .W(8)) dut1 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .frame_start(frame_start),
    .ch_data(ch_data1), .ch_valid(ch_valid1), .frame_done(frame_done1),
    .sync_err(sync_err1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample just after the edge that consumed them.
  task automatic step(input logic r, input logic v, input logic [7:0] d, input logic fs);
    @(negedge clk);
    rst = r; din_valid = v; din = d; frame_start = fs;
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [31:0] data, input logic [3:0] vld,
                      input logic fd, input logic se, input logic bsy);
    check({tag, ".data"}, ch_data, data);
    check({tag, ".valid"}, ch_valid, vld);
    check({tag, ".done"}, frame_done, fd);
    check({tag, ".serr"}, sync_err, se);
    check({tag, ".busy"}, busy, bsy);
  endtask

  initial begin
    // reset state
    step(1, 1, 8'hEE, 1);
    chk4("rst", 32'h0, 4'b0000, 0, 0, 0);

    // back-to-back frame
    step(0, 1, 8'hA1, 1); chk4("bb0", 32'h0000_00A1, 4'b0001, 0, 0, 1);
    step(0, 1, 8'hB2, 0); chk4("bb1", 32'h0000_B2A1, 4'b0010, 0, 0, 1);
    step(0, 1, 8'hC3, 0); chk4("bb2", 32'h00C3_B2A1, 4'b0100, 0, 0, 1);
    step(0, 1, 8'hD4, 0); chk4("bb3", 32'hD4C3_B2A1, 4'b1000, 1, 0, 1);

    // same frame with two idle cycles between words
    step(1, 0, 8'h00, 0); chk4("rst2", 32'h0, 4'b0000, 0, 0, 0);
    step(0, 1, 8'hA1, 1); chk4("gp0", 32'h0000_00A1, 4'b0001, 0, 0, 1);
    step(0, 0, 8'hFF, 1); chk4("gp0a", 32'h0000_00A1, 4'b0000, 0, 0, 1);
    step(0, 0, 8'hFF, 0); chk4("gp0b", 32'h0000_00A1, 4'b0000, 0, 0, 1);
    step(0, 1, 8'hB2, 0); chk4("gp1", 32'h0000_B2A1, 4'b0010, 0, 0, 1);
    step(0, 0, 8'h00, 0); chk4("gp1a", 32'h0000_B2A1, 4'b0000, 0, 0, 1);
    step(0, 0, 8'h00, 0); chk4("gp1b", 32'h0000_B2A1, 4'b0000, 0, 0, 1);
    step(0, 1, 8'hC3, 0); chk4("gp2", 32'h00C3_B2A1, 4'b0100, 0, 0, 1);
    step(0, 0, 8'h00, 0); chk4("gp2a", 32'h00C3_B2A1, 4'b0000, 0, 0, 1);
    step(0, 0, 8'h00, 0); chk4("gp2b", 32'h00C3_B2A1, 4'b0000, 0, 0, 1);
    step(0, 1, 8'hD4, 0); chk4("gp3", 32'hD4C3_B2A1, 4'b1000, 1, 0, 1);

    // premature marker resync
    step(0, 1, 8'h11, 1); chk4("pm0", 32'hD4C3_B211, 4'b0001, 0, 0, 1);
    step(0, 1, 8'h22, 0); chk4("pm1", 32'hD4C3_2211, 4'b0010, 0, 0, 1);
    step(0, 1, 8'h33, 1); chk4("pm2", 32'hD4C3_2233, 4'b0001, 0, 1, 1);
    step(0, 1, 8'h44, 0); chk4("pm3", 32'hD4C3_4433, 4'b0010, 0, 0, 1);
    step(0, 1, 8'hAA, 0); chk4("pm4", 32'hD4AA_4433, 4'b0100, 0, 0, 1);
    step(0, 1, 8'hBB, 0); chk4("pm5", 32'hBBAA_4433, 4'b1000, 1, 0, 1);

    // missing marker after a complete frame
    step(0, 1, 8'h55, 0); chk4("mm0", 32'hBBAA_4433, 4'b0000, 0, 1, 0);
    step(0, 1, 8'h66, 0); chk4("mm1", 32'hBBAA_4433, 4'b0000, 0, 0, 0);
    step(0, 1, 8'h77, 1); chk4("mm2", 32'hBBAA_4477, 4'b0001, 0, 0, 1);

    // idle drop after reset, then reset mid-frame
    step(1, 0, 8'h00, 0); chk4("rst3", 32'h0, 4'b0000, 0, 0, 0);
    step(0, 1, 8'h99, 0); chk4("id0", 32'h0, 4'b0000, 0, 0, 0);
    step(0, 1, 8'hA1, 1); chk4("rm0", 32'h0000_00A1, 4'b0001, 0, 0, 1);
    step(0, 1, 8'hB2, 0); chk4("rm1", 32'h0000_B2A1, 4'b0010, 0, 0, 1);
    step(1, 1, 8'hC3, 0); chk4("rm2", 32'h0, 4'b0000, 0, 0, 0);
    step(0, 1, 8'h12, 0); chk4("rm3", 32'h0, 4'b0000, 0, 0, 0);

    // single-channel build
    step(1, 0, 8'h00, 0);
    check("n1.rst.valid", ch_valid1, 1'b0);
    check("n1.rst.data", ch_data1, 8'h00);
    step(0, 1, 8'h5A, 1);
    check("n1.f0.valid", ch_valid1, 1'b1);
    check("n1.f0.done", frame_done1, 1'b1);
    check("n1.f0.data", ch_data1, 8'h5A);
    check("n1.f0.busy", busy1, 1'b1);
    step(0, 1, 8'h6B, 1);
    check("n1.f1.valid", ch_valid1, 1'b1);
    check("n1.f1.done", frame_done1, 1'b1);
    check("n1.f1.serr", sync_err1, 1'b0);
    check("n1.f1.data", ch_data1, 8'h6B);
    step(0, 1, 8'h7C, 0);
    check("n1.f2.serr", sync_err1, 1'b1);
    check("n1.f2.valid", ch_valid1, 1'b0);
    check("n1.f2.data", ch_data1, 8'h6B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
